// File: rtl/arb_requester.sv
// Requester-side companion to the 4-way req/gnt arbiter: turns a burst command into req/beat handshakes.
// Optional grant-timeout abort is enabled by defining GNT_TIMEOUT_EN.
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int WAIT_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              gnt,
    output logic              req,
    output logic              busy,
    output logic              beat_en,
    output logic              last,
    output logic              done,
    output logic              err,
    output logic [WAIT_W-1:0] wait_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REL    = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > (2 ** WAIT_W) - 1) begin : g_bad_timeout
        $error("arb_requester: TIMEOUT must lie in 1..2**WAIT_W-1");
    end

    state_t             state;
    logic [LEN_W-1:0]   remaining;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               first_seen;
    logic               abort;
    logic               aborted;

    assign beat_en = (state == ACTIVE) && gnt;
    assign last    = beat_en && (remaining == '0);

`ifdef GNT_TIMEOUT_EN
    logic [WAIT_W-1:0] to_cnt;

    // Abort on the TIMEOUT-th consecutive gnt-low ACTIVE cycle; a grant in that cycle wins.
    assign abort = (state == ACTIVE) && !gnt && (to_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt  <= '0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= (state == REL) && !gnt && aborted;
            if (state != ACTIVE || gnt) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (abort) begin
                aborted <= 1'b1;
            end else if (state == REL && !gnt) begin
                aborted <= 1'b0;
            end
        end
    end
`else
    assign abort   = 1'b0;
    assign aborted = 1'b0;
    assign err     = 1'b0;
`endif

    // NOTE: every register below uses non-blocking assignment so all of them see the
    // pre-edge state; a blocking write would leak a new value into later statements.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            remaining   <= '0;
            wait_cnt    <= '0;
            wait_cycles <= '0;
            first_seen  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACTIVE;
                        req        <= 1'b1;
                        busy       <= 1'b1;
                        remaining  <= len;
                        wait_cnt   <= '0;
                        first_seen <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (gnt) begin
                        if (!first_seen) begin
                            first_seen  <= 1'b1;
                            wait_cycles <= wait_cnt;
                        end
                        if (remaining == '0) begin
                            state <= REL;
                            req   <= 1'b0;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end else begin
                        if (!first_seen && wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (abort) begin
                            state     <= REL;
                            req       <= 1'b0;
                            remaining <= '0;
                        end
                    end
                end
                REL: begin
                    // Hold until the arbiter drops gnt so it is back in idle before our next req.
                    if (!gnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= !aborted;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_done_err_excl : assert property (@(posedge clk) disable iff (!n_rst) !(done && err));
    a_no_beat_in_rel : assert property (@(posedge clk) disable iff (!n_rst) (state == REL) |-> !beat_en);
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: registered arbiter model plus a completion scoreboard.
// Timeout scenario is exercised only when GNT_TIMEOUT_EN is defined.
module tb_arb_requester;

    localparam int LEN_W   = 4;
    localparam int WAIT_W  = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        int beats;
        int waitc;
        bit err;
    } exp_t;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              gnt;
    logic              req;
    logic              busy;
    logic              beat_en;
    logic              last;
    logic              done;
    logic              err;
    logic [WAIT_W-1:0] wait_cycles;

    int   n_checks = 0;
    int   n_bad    = 0;
    exp_t sb_q[$];

    bit   arb_on    = 1'b1;
    bit   req_prev  = 1'b0;
    int   drop_left = 0;

    arb_requester #(
        .LEN_W   (LEN_W),
        .WAIT_W  (WAIT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .len         (len),
        .gnt         (gnt),
        .req         (req),
        .busy        (busy),
        .beat_en     (beat_en),
        .last        (last),
        .done        (done),
        .err         (err),
        .wait_cycles (wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One cycle: the arbiter model registers req, so gnt follows req one cycle later.
    task automatic tick();
        req_prev = req;
        @(posedge clk);
        #1;
        if (drop_left > 0) begin
            gnt = 1'b0;
            drop_left--;
        end else begin
            gnt = arb_on & req_prev;
        end
    endtask

    // Completion monitor: pops one expectation per done/err pulse.
    int   mon_beats = 0;
    int   mon_lasts = 0;
    int   mon_last_at = 0;
    int   mon_rel_beats = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!n_rst) begin
            mon_beats = 0;
            mon_lasts = 0;
            mon_last_at = 0;
            mon_rel_beats = 0;
        end else begin
            if (beat_en) begin
                mon_beats++;
                if (last) begin
                    mon_lasts++;
                    mon_last_at = mon_beats;
                end
            end
            if (busy && !req && beat_en) mon_rel_beats++;
            if (done || err) begin
                check("done_err_excl", done & err, 0);
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_beats", mon_beats, mon_e.beats);
                    check("sb_err", err, mon_e.err);
                    check("sb_wait", wait_cycles, mon_e.waitc);
                    check("sb_last_cnt", mon_lasts, mon_e.err ? 0 : 1);
                    if (!mon_e.err) check("sb_last_pos", mon_last_at, mon_e.beats);
                    check("sb_rel_beats", mon_rel_beats, 0);
                end
                mon_beats = 0;
                mon_lasts = 0;
                mon_last_at = 0;
                mon_rel_beats = 0;
            end
        end
    end

    task automatic push_exp(input int beats, input int waitc, input bit e);
        exp_t x;
        x.beats = beats;
        x.waitc = waitc;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    task automatic run_burst(input string tag, input logic [LEN_W-1:0] l, input int drop_at,
                             input int drop_cycles, input bit grant_en, input int exp_beats,
                             input int exp_wait, input bit exp_err, input int exp_req, input int exp_run);
        int beats = 0, run = 0, max_run = 0, req_cyc = 0, req_rise = 0, n_done = 0, n_err = 0;
        bit fin = 1'b0, dropped = 1'b0, req_d = 1'b0;
        arb_on = grant_en;
        push_exp(exp_beats, exp_wait, exp_err);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            tick();
            start = (cyc == 0);
            len   = l;
            @(negedge clk);
            if (beat_en) begin
                beats++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (req) req_cyc++;
            if (req && !req_d) req_rise++;
            req_d = req;
            if (done) n_done++;
            if (err) n_err++;
            if (done || err) fin = 1'b1;
            if (!dropped && drop_at >= 0 && beats == drop_at) begin
                dropped   = 1'b1;
                drop_left = drop_cycles;
            end
        end
        start = 1'b0;
        check({tag, "_finished"}, fin, 1);
        check({tag, "_beats"}, beats, exp_beats);
        check({tag, "_max_run"}, max_run, exp_run);
        check({tag, "_req_cycles"}, req_cyc, exp_req);
        check({tag, "_req_rises"}, req_rise, 1);
        check({tag, "_done_cnt"}, n_done, exp_err ? 0 : 1);
        check({tag, "_err_cnt"}, n_err, exp_err ? 1 : 0);
        arb_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int beats;
        n_rst = 1'b0;
        start = 1'b0;
        len   = '0;
        gnt   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wait", wait_cycles, 0);
        check("rst_beat_en", beat_en, 0);
        check("rst_last", last, 0);
        tick();
        n_rst = 1'b1;
        @(negedge clk);

        // Nominal single beat, cycle by cycle.
        tick(); start = 1'b1; len = 4'd0; push_exp(1, 1, 1'b0);
        @(negedge clk); check("nom_c0_busy", busy, 0);
        tick(); start = 1'b0;
        @(negedge clk); check("nom_c1_req", req, 1); check("nom_c1_busy", busy, 1); check("nom_c1_beat", beat_en, 0);
        tick();
        @(negedge clk); check("nom_c2_beat", beat_en, 1); check("nom_c2_last", last, 1); check("nom_c2_req", req, 1);
        tick();
        @(negedge clk); check("nom_c3_req", req, 0); check("nom_c3_beat", beat_en, 0); check("nom_c3_busy", busy, 1);
        tick();
        @(negedge clk); check("nom_c4_busy", busy, 1); check("nom_c4_done", done, 0);
        tick();
        @(negedge clk); check("nom_c5_done", done, 1); check("nom_c5_busy", busy, 0); check("nom_c5_wait", wait_cycles, 1);
        tick();
        @(negedge clk); check("nom_c6_done", done, 0);

        // Reset in ACTIVE with remaining=3 while a beat is being offered.
        arb_on = 1'b0;
        tick(); start = 1'b1; len = 4'd3;
        @(negedge clk);
        tick(); start = 1'b0;
        @(negedge clk); check("mrst_pre_req", req, 1);
        tick(); gnt = 1'b1;
        @(negedge clk); check("mrst_pre_beat", beat_en, 1);
        #1 n_rst = 1'b0;
        #1;
        check("mrst_req", req, 0);
        check("mrst_busy", busy, 0);
        check("mrst_beat", beat_en, 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        @(negedge clk);
        check("mrst_post_busy", busy, 0);
        check("mrst_post_req", req, 0);
        check("mrst_post_wait", wait_cycles, 0);
        arb_on = 1'b1;

        run_burst("len7", 4'd7, -1, 0, 1'b1, 8, 1, 1'b0, 9, 8);
        run_burst("len15", 4'd15, -1, 0, 1'b1, 16, 1, 1'b0, 17, 16);
        run_burst("pause", 4'd3, 2, 3, 1'b1, 4, 1, 1'b0, 8, 2);
        run_burst("late_gnt", 4'd2, 0, 3, 1'b1, 3, 3, 1'b0, 6, 3);

        // start held high: one burst per IDLE visit, 6-cycle period for len=1.
        for (int i = 0; i < 4; i++) push_exp(2, 1, 1'b0);
        dones = 0;
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); start = 1'b1; len = 4'd1;
            @(negedge clk);
            if (done) dones++;
            if (beat_en) beats++;
        end
        for (int i = 0; i < 60 && !(dones == 4 && !busy); i++) begin
            tick(); start = 1'b0;
            @(negedge clk);
            if (done) dones++;
            if (beat_en) beats++;
        end
        start = 1'b0;
        check("hold_dones", dones, 4);
        check("hold_beats", beats, 8);
        check("hold_idle", busy, 0);

`ifdef GNT_TIMEOUT_EN
        run_burst("timeout", 4'd3, -1, 0, 1'b0, 0, 1, 1'b1, TIMEOUT, 0);
`endif

        repeat (3) begin
            tick();
            @(negedge clk);
        end
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
